// File: rtl/vga_scene_pkg.sv
// Scene table, FSM states and lookup shared by the VGA scene sequencer.
// Optional fade build: define VGA_SCENE_FADE_EN.
package vga_scene_pkg;

   typedef enum logic [1:0] {
      HOLD,
      FADE_OUT,
      FADE_IN
   } state_e;

   typedef struct packed {
      logic [2:0] patmode;
      logic [2:0] inymode;
      logic [1:0] timemode;
   } scene_cfg_t;

   localparam scene_cfg_t SCENE_TABLE [0:7] = '{
      '{3'd0, 3'd0, 2'd0},
      '{3'd1, 3'd2, 2'd1},
      '{3'd2, 3'd4, 2'd2},
      '{3'd3, 3'd6, 2'd3},
      '{3'd4, 3'd1, 2'd0},
      '{3'd5, 3'd3, 2'd1},
      '{3'd6, 3'd5, 2'd2},
      '{3'd7, 3'd7, 2'd3}
   };

   function automatic scene_cfg_t scene_lookup(input logic [2:0] idx);
      return SCENE_TABLE[idx];
   endfunction

endpackage

// File: rtl/vga_scene_sequencer_if.sv
// Control/status bundle between the frame timing side and the scene sequencer.
// Master drives frame timing and controls; slave returns scene state.
interface vga_scene_sequencer_if #(
   parameter int TM_W = 20
);
   logic            frame_start;
   logic            run;
   logic            step_req;
   logic [7:0]      hold_frames;
   logic [2:0]      scene_idx;
   logic [2:0]      patmode;
   logic [2:0]      inymode;
   logic [1:0]      timemode;
   logic [TM_W-1:0] tm;
   logic            scene_change;
   logic [7:0]      fade_level;

   modport master (
      output frame_start, run, step_req, hold_frames,
      input  scene_idx, patmode, inymode, timemode,
      input  tm, scene_change, fade_level
   );

   modport slave (
      input  frame_start, run, step_req, hold_frames,
      output scene_idx, patmode, inymode, timemode,
      output tm, scene_change, fade_level
   );
endinterface

// File: rtl/vga_fade_ramp.sv
// Saturating 8-bit brightness ramp; used only when VGA_SCENE_FADE_EN is defined.
module vga_fade_ramp #(
   parameter int FADE_STEP = 16
) (
   input  logic [7:0] i_level,
   input  logic       i_up,
   output logic [7:0] o_next,
   output logic       o_at_min,
   output logic       o_at_max
);
   localparam logic [8:0] STEP9 = 9'(FADE_STEP);

   logic [8:0] w_sum;

   assign w_sum = {1'b0, i_level} + STEP9;

   always_comb begin
      o_next = i_level;
      if (i_up)
         o_next = w_sum[8] ? 8'hFF : w_sum[7:0];
      else if ({1'b0, i_level} < STEP9)
         o_next = 8'h00;
      else
         o_next = i_level - STEP9[7:0];
   end

   assign o_at_min = (i_level == 8'h00);
   assign o_at_max = (o_next == 8'hFF);
endmodule

// File: rtl/vga_scene_sequencer.sv
// Frame-synchronous scene scheduler: time base, scene index and mode selects.
// Define VGA_SCENE_FADE_EN to fade out/in around every scene change.
module vga_scene_sequencer
   import vga_scene_pkg::*;
#(
   parameter int NUM_SCENES = 8,
   parameter int TM_W       = 20,
   parameter int FADE_STEP  = 16
) (
   input logic clk,
   input logic rst_n,
   vga_scene_sequencer_if.slave bus
);
   localparam logic [2:0] IDX_LAST = 3'(NUM_SCENES - 1);

   state_e          r_state;
   logic [2:0]      r_idx;
   scene_cfg_t      r_cfg;
   logic [TM_W-1:0] r_tm;
   logic [7:0]      r_hold_cnt;
   logic            r_step_pend;
   logic            r_change;

   logic [7:0]      w_lim;
   logic            w_due;
   logic [2:0]      w_next_idx;
   scene_cfg_t      w_next_cfg;

   // hold_frames of 0 behaves as 1; >= catches a limit lowered mid-scene
   assign w_lim      = (bus.hold_frames == 8'd0) ? 8'd0
                     : bus.hold_frames - 8'd1;
   assign w_due      = r_step_pend | bus.step_req
                     | (bus.run & (r_hold_cnt >= w_lim));
   assign w_next_idx = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
   assign w_next_cfg = scene_lookup(w_next_idx);

`ifdef VGA_SCENE_FADE_EN
   logic [7:0] r_fade;
   logic [7:0] w_ramp_next;
   logic       w_at_min;
   logic       w_at_max;

   vga_fade_ramp #(
      .FADE_STEP (FADE_STEP)
   ) u_ramp (
      .i_level  (r_fade),
      .i_up     (r_state == FADE_IN),
      .o_next   (w_ramp_next),
      .o_at_min (w_at_min),
      .o_at_max (w_at_max)
   );

   assign bus.fade_level = r_fade;
`else
   assign bus.fade_level = 8'hFF;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= HOLD;
         r_idx       <= 3'd0;
         r_cfg       <= scene_lookup(3'd0);
         r_tm        <= '0;
         r_hold_cnt  <= 8'd0;
         r_step_pend <= 1'b0;
         r_change    <= 1'b0;
`ifdef VGA_SCENE_FADE_EN
         r_fade      <= 8'hFF;
`endif
      end else begin
         r_change <= 1'b0;
         if (bus.step_req)
            r_step_pend <= 1'b1;
         if (bus.frame_start) begin
            if (bus.run)
               r_tm <= r_tm + 1'b1;
            unique case (r_state)
               HOLD: begin
                  if (w_due) begin
                     r_step_pend <= 1'b0;
                     r_hold_cnt  <= 8'd0;
`ifdef VGA_SCENE_FADE_EN
                     r_state     <= FADE_OUT;
`else
                     r_idx       <= w_next_idx;
                     r_cfg       <= w_next_cfg;
                     r_change    <= 1'b1;
`endif
                  end else if (bus.run) begin
                     r_hold_cnt <= r_hold_cnt + 8'd1;
                  end
               end
`ifdef VGA_SCENE_FADE_EN
               // scene swaps only once the screen is fully dark
               FADE_OUT: begin
                  if (bus.run) begin
                     if (w_at_min) begin
                        r_idx    <= w_next_idx;
                        r_cfg    <= w_next_cfg;
                        r_change <= 1'b1;
                        r_state  <= FADE_IN;
                     end else begin
                        r_fade <= w_ramp_next;
                     end
                  end
               end
               FADE_IN: begin
                  if (bus.run) begin
                     r_fade <= w_ramp_next;
                     if (w_at_max) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= 8'd0;
                     end
                  end
               end
`endif
               default: r_state <= HOLD;
            endcase
         end
      end
   end

   assign bus.scene_idx    = r_idx;
   assign bus.patmode      = r_cfg.patmode;
   assign bus.inymode      = r_cfg.inymode;
   assign bus.timemode     = r_cfg.timemode;
   assign bus.tm           = r_tm;
   assign bus.scene_change = r_change;
endmodule
